// File: rtl/adder_pipe_dly.sv
// Fixed-latency adder pipeline: {co,sum} = a + b + ci, carried through LATENCY
// register stages with valid/ready flow control and bubble collapsing.
module adder_pipe_dly #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             busy
);

  localparam int DW = WIDTH + 1;

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;
  logic [LATENCY-1:0] adv_s;
  logic [DW-1:0]      data_q [LATENCY];
  logic [DW-1:0]      data_d [LATENCY];
  logic [DW-1:0]      add_s;
  logic               busy_q;

  function automatic logic [DW-1:0] add_fn(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic             c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // Stage i may load unless it and every stage downstream of it are full
  // while the consumer is stalling.
  always_comb begin
    logic full_v;
    adv_s = '0;
    for (int i = 0; i < LATENCY; i++) begin
      full_v = 1'b1;
      for (int j = i; j < LATENCY; j++) begin
        full_v = full_v & valid_q[j];
      end
      adv_s[i] = !full_v || out_ready;
    end
  end

  // Next-state for every stage; operands are only sampled on an accepted transfer.
  always_comb begin
    add_s   = add_fn(a, b, ci);
    valid_d = valid_q;
    data_d  = data_q;
    if (adv_s[0]) begin
      valid_d[0] = in_valid;
      data_d[0]  = in_valid ? add_s : data_q[0];
    end else begin
      valid_d[0] = valid_q[0];
      data_d[0]  = data_q[0];
    end
    for (int i = 1; i < LATENCY; i++) begin
      if (adv_s[i]) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
      end else begin
        valid_d[i] = valid_q[i];
        data_d[i]  = data_q[i];
      end
    end
  end

  // Pipeline registers; reset discards every in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= |valid_d;
    end
  end

  assign in_ready  = adv_s[0];
  assign out_valid = valid_q[LATENCY-1];
  assign sum       = data_q[LATENCY-1][WIDTH-1:0];
  assign co        = data_q[LATENCY-1][WIDTH];
  assign busy      = busy_q;

endmodule

// File: tb/tb_adder_pipe_dly.sv
// Scoreboard bench for adder_pipe_dly: latency, streaming, wrap, backpressure,
// random gaps/stalls and asynchronous reset with results in flight.
module tb_adder_pipe_dly;
  localparam int W = 4;
  localparam int L = 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;
  logic         busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc_n    = 0;
  int s_cyc;
  logic acc, otx, o_val, o_rdy, o_co, o_busy;
  logic [W-1:0] o_sum;
  logic [W:0] exp_q[$];
  int         ts_q[$];

  adder_pipe_dly #(.WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c);
    int s;
    s = int'(x) + int'(y) + int'(c);
    return s[W:0];
  endfunction

  // Samples DUT state at the falling edge, then advances past the next rising edge.
  task automatic cyc();
    @(negedge clk);
    s_cyc  = cyc_n;
    acc    = in_valid && in_ready;
    otx    = out_valid && out_ready;
    o_val  = out_valid;
    o_rdy  = in_ready;
    o_sum  = sum;
    o_co   = co;
    o_busy = busy;
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op();
    a  = W'($urandom_range(0, 2**W - 1));
    b  = W'($urandom_range(0, 2**W - 1));
    ci = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_hold: out_valid=%b busy=%b expected 0 0", out_valid, busy);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if ({in_ready, out_valid, busy, co, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0})
      $display("FAIL reset_state: rdy=%b ov=%b busy=%b co=%b sum=%h expected 1 0 0 0 0", in_ready, out_valid, busy, co, sum);
    else pass_cnt++;
  endtask

  task automatic test_single();
    in_valid = 1'b1; a = 4'd3; b = 4'd4; ci = 1'b0; out_ready = 1'b1;
    cyc();
    chk_cnt++;
    if (acc !== 1'b1) $display("FAIL single_accept: accepted=%b expected 1", acc);
    else pass_cnt++;
    in_valid = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      rand_op();
      cyc();
      chk_cnt++;
      if (o_val !== (t == L)) $display("FAIL single_valid: cycle %0d out_valid=%b expected %b", t, o_val, (t == L));
      else pass_cnt++;
      if (t == L) begin
        chk_cnt++;
        if ({o_co, o_sum} !== 5'h07) $display("FAIL single_data: got %h expected 07", {o_co, o_sum});
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_stream();
    int sent = 0, n_out = 0, t0;
    logic [W:0] e;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && (sent < 8 || exp_q.size() > 0); c++) begin
      in_valid = (sent < 8);
      rand_op();
      cyc();
      if (in_valid) begin
        chk_cnt++;
        if (o_rdy !== 1'b1) $display("FAIL stream_ready: in_ready=%b expected 1", o_rdy);
        else pass_cnt++;
      end
      if (otx) begin
        chk_cnt++;
        n_out++;
        if (exp_q.size() == 0) $display("FAIL stream_data: spurious output %h", {o_co, o_sum});
        else begin
          e = exp_q.pop_front(); t0 = ts_q.pop_front();
          if ({o_co, o_sum} !== e || s_cyc - t0 != L)
            $display("FAIL stream_data: got %h after %0d cycles expected %h after %0d", {o_co, o_sum}, s_cyc - t0, e, L);
          else pass_cnt++;
        end
      end
      if (acc) begin exp_q.push_back(golden(a, b, ci)); ts_q.push_back(s_cyc); sent++; end
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (n_out != 8 || exp_q.size() != 0) $display("FAIL stream_count: outputs=%0d pending=%0d expected 8 0", n_out, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic         tc [3];
    logic [W:0]   te [3];
    int sent = 0, n_out = 0;
    logic [W:0] e;
    ta[0] = 4'hF; tb[0] = 4'hF; tc[0] = 1'b1; te[0] = 5'h1F;
    ta[1] = 4'hF; tb[1] = 4'h0; tc[1] = 1'b1; te[1] = 5'h10;
    ta[2] = 4'h0; tb[2] = 4'h0; tc[2] = 1'b0; te[2] = 5'h00;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && (sent < 3 || exp_q.size() > 0); c++) begin
      in_valid = (sent < 3);
      if (sent < 3) begin a = ta[sent]; b = tb[sent]; ci = tc[sent]; end
      else rand_op();
      cyc();
      if (otx) begin
        chk_cnt++;
        n_out++;
        if (exp_q.size() == 0) $display("FAIL wrap_data: spurious output %h", {o_co, o_sum});
        else begin
          e = exp_q.pop_front(); void'(ts_q.pop_front());
          if ({o_co, o_sum} !== e) $display("FAIL wrap_data: got %h expected %h", {o_co, o_sum}, e);
          else pass_cnt++;
        end
      end
      if (acc) begin exp_q.push_back(te[sent]); ts_q.push_back(s_cyc); sent++; end
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (n_out != 3 || exp_q.size() != 0) $display("FAIL wrap_count: outputs=%0d pending=%0d expected 3 0", n_out, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ta [5];
    logic [W-1:0] tb [5];
    logic         tc [5];
    int sent = 0, n_out = 0;
    logic [W:0] e;
    for (int k = 0; k < 5; k++) begin
      ta[k] = W'($urandom_range(0, 15)); tb[k] = W'($urandom_range(0, 15)); tc[k] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      a = ta[sent]; b = tb[sent]; ci = tc[sent];
      cyc();
      if (acc) begin exp_q.push_back(golden(a, b, ci)); ts_q.push_back(s_cyc); sent++; end
    end
    chk_cnt++;
    if (sent != L || o_rdy !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL bp_full: accepted=%0d in_ready=%b busy=%b expected %0d 0 1", sent, o_rdy, o_busy, L);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() == 0) $display("FAIL bp_hold: nothing accepted, out_valid=%b", o_val);
    else if (o_val !== 1'b1 || {o_co, o_sum} !== exp_q[0])
      $display("FAIL bp_hold: out_valid=%b data=%h expected 1 %h", o_val, {o_co, o_sum}, exp_q[0]);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && (sent < 5 || exp_q.size() > 0); c++) begin
      in_valid = (sent < 5);
      if (sent < 5) begin a = ta[sent]; b = tb[sent]; ci = tc[sent]; end
      else rand_op();
      cyc();
      if (otx) begin
        chk_cnt++;
        n_out++;
        if (exp_q.size() == 0) $display("FAIL bp_data: spurious output %h", {o_co, o_sum});
        else begin
          e = exp_q.pop_front(); void'(ts_q.pop_front());
          if ({o_co, o_sum} !== e) $display("FAIL bp_data: got %h expected %h", {o_co, o_sum}, e);
          else pass_cnt++;
        end
      end
      if (acc) begin exp_q.push_back(golden(a, b, ci)); ts_q.push_back(s_cyc); sent++; end
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (n_out != 5 || exp_q.size() != 0) $display("FAIL bp_count: outputs=%0d pending=%0d expected 5 0", n_out, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_random_gaps();
    int n_in = 0, n_out = 0;
    logic [W:0] e;
    logic       prev_stall = 1'b0;
    logic [W:0] prev_data = '0;
    for (int c = 0; c < 150 && (c < 80 || exp_q.size() > 0); c++) begin
      rand_op();
      in_valid  = (c < 80) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = (c < 80) ? ($urandom_range(0, 9) < 7) : 1'b1;
      cyc();
      if (prev_stall) begin
        chk_cnt++;
        if (o_val !== 1'b1 || {o_co, o_sum} !== prev_data)
          $display("FAIL gaps_stall: out_valid=%b data=%h expected 1 %h", o_val, {o_co, o_sum}, prev_data);
        else pass_cnt++;
      end
      prev_stall = o_val && !out_ready;
      prev_data  = {o_co, o_sum};
      if (otx) begin
        chk_cnt++;
        n_out++;
        if (exp_q.size() == 0) $display("FAIL gaps_data: spurious output %h", {o_co, o_sum});
        else begin
          e = exp_q.pop_front(); void'(ts_q.pop_front());
          if ({o_co, o_sum} !== e) $display("FAIL gaps_data: got %h expected %h", {o_co, o_sum}, e);
          else pass_cnt++;
        end
      end
      if (acc) begin exp_q.push_back(golden(a, b, ci)); ts_q.push_back(s_cyc); n_in++; end
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (n_out != n_in || exp_q.size() != 0) $display("FAIL gaps_count: outputs=%0d accepted=%0d pending=%0d", n_out, n_in, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_in_flight();
    int sent = 0, n_out = 0;
    logic [W:0] e;
    out_ready = 1'b0;
    for (int c = 0; c < 6 && sent < 3; c++) begin
      in_valid = 1'b1;
      rand_op();
      cyc();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    #2; rst_n = 1'b0; #1;
    chk_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_flight: out_valid=%b busy=%b in_ready=%b expected 0 0 1", out_valid, busy, in_ready);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); ts_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      rand_op();
      cyc();
      chk_cnt++;
      if (o_val !== 1'b0) $display("FAIL rst_stale: cycle %0d out_valid=%b expected 0", c, o_val);
      else pass_cnt++;
    end
    sent = 0;
    for (int c = 0; c < 20 && (sent < 1 || exp_q.size() > 0); c++) begin
      in_valid = (sent < 1);
      rand_op();
      cyc();
      if (otx) begin
        chk_cnt++;
        n_out++;
        if (exp_q.size() == 0) $display("FAIL rst_new: spurious output %h", {o_co, o_sum});
        else begin
          e = exp_q.pop_front(); void'(ts_q.pop_front());
          if ({o_co, o_sum} !== e) $display("FAIL rst_new: got %h expected %h", {o_co, o_sum}, e);
          else pass_cnt++;
        end
      end
      if (acc) begin exp_q.push_back(golden(a, b, ci)); ts_q.push_back(s_cyc); sent++; end
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (n_out != 1 || exp_q.size() != 0) $display("FAIL rst_new_count: outputs=%0d pending=%0d expected 1 0", n_out, exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_wrap();
    test_backpressure();
    test_random_gaps();
    test_reset_in_flight();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
